// File: rtl/nested_loop_sched_if.sv
// Event channel between the nested-loop scheduler and its datapath.
// The scheduler is the master: it offers events, and the datapath answers with evt_ready.
interface nested_loop_sched_if;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_type;
    logic [7:0] x_idx;
    logic [7:0] y_idx;
    logic [7:0] act1;
    logic [7:0] act2;

    modport master (
        output evt_valid, evt_type, x_idx, y_idx, act1, act2,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_type, x_idx, y_idx, act1, act2,
        output evt_ready
    );
endinterface

// File: rtl/nested_loop_sched.sv
// Two-level loop scheduler: for each outer index it issues one outer event,
// followed by inner_n inner events, all handshaked on a valid/ready channel.
module nested_loop_sched (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          outer_n,
    input  logic [7:0]          inner_n,
    output logic                busy,
    output logic                done,
    nested_loop_sched_if.master evt
);
    typedef enum logic [1:0] {IDLE, OUTER, INNER, DONE} state_t;

    state_t     state, state_d;
    logic [7:0] outer_q, outer_d;
    logic [7:0] inner_q, inner_d;
    logic [7:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [7:0] act1_q, act1_d;
    logic [7:0] act2_q, act2_d;
    logic       x_last, y_last;

    // Counts are non-zero whenever these are consulted, so the subtraction cannot wrap.
    assign x_last = (x_q == outer_q - 8'd1);
    assign y_last = (y_q == inner_q - 8'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            outer_q <= '0;
            inner_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            act1_q  <= '0;
            act2_q  <= '0;
        end else begin
            state   <= state_d;
            outer_q <= outer_d;
            inner_q <= inner_d;
            x_q     <= x_d;
            y_q     <= y_d;
            act1_q  <= act1_d;
            act2_q  <= act2_d;
        end
    end

    always_comb begin
        state_d = state;
        outer_d = outer_q;
        inner_d = inner_q;
        x_d     = x_q;
        y_d     = y_q;
        act1_d  = act1_q;
        act2_d  = act2_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    outer_d = outer_n;
                    inner_d = inner_n;
                    x_d     = '0;
                    y_d     = '0;
                    act1_d  = '0;
                    act2_d  = '0;
                    state_d = (outer_n == 8'd0) ? DONE : OUTER;
                end
            end
            OUTER: begin
                if (evt.evt_ready) begin
                    act2_d = act2_q + 8'd1;
                    y_d    = '0;
                    if (inner_q != 8'd0) begin
                        state_d = INNER;
                    end else if (!x_last) begin
                        x_d     = x_q + 8'd1;
                        state_d = OUTER;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            INNER: begin
                if (evt.evt_ready) begin
                    act1_d = act2_q;
                    if (!y_last) begin
                        y_d = y_q + 8'd1;
                    end else if (!x_last) begin
                        x_d     = x_q + 8'd1;
                        state_d = OUTER;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign evt.evt_valid = (state == OUTER) || (state == INNER);
    assign evt.evt_type  = (state == INNER);
    assign evt.x_idx     = x_q;
    assign evt.y_idx     = y_q;
    assign evt.act1      = act1_q;
    assign evt.act2      = act2_q;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
endmodule

// File: tb/tb_nested_loop_sched.sv
// Bench for nested_loop_sched: randomized runs checked against a nested-loop
// reference model of the event stream, plus reset, abort and boundary scenarios.
module tb_nested_loop_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] outer_n = '0;
    logic [7:0] inner_n = '0;
    logic       busy;
    logic       done;
    int         checks = 0;
    int         errors = 0;

    nested_loop_sched_if ev ();

    nested_loop_sched dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .outer_n (outer_n),
        .inner_n (inner_n),
        .busy    (busy),
        .done    (done),
        .evt     (ev.master)
    );

    always #5 clk = ~clk;

    // mode 0: ready always high, 1: ready pattern 1,0,0, 2: random ready.
    // poke: hold start high with random counts throughout the run.
    task automatic run_seq(input logic [7:0] on, input logic [7:0] in,
                           input int mode, input bit poke, input string name);
        bit         e_t[$];
        logic [7:0] e_x[$], e_y[$], e_a1[$], e_a2[$];
        logic [7:0] a1, a2, fx, fy;
        int         n, idx, cyc;
        bit         seen_done, rdy;
        a1 = '0;
        a2 = '0;
        for (int x = 0; x < int'(on); x++) begin
            e_t.push_back(1'b0); e_x.push_back(8'(x)); e_y.push_back(8'd0);
            e_a1.push_back(a1); e_a2.push_back(a2);
            a2 = a2 + 8'd1;
            for (int y = 0; y < int'(in); y++) begin
                e_t.push_back(1'b1); e_x.push_back(8'(x)); e_y.push_back(8'(y));
                e_a1.push_back(a1); e_a2.push_back(a2);
                a1 = a2;
            end
        end
        n  = e_t.size();
        fx = (on == 8'd0) ? 8'd0 : on - 8'd1;
        fy = (on != 8'd0 && in != 8'd0) ? in - 8'd1 : 8'd0;
        idx = 0;
        cyc = 0;
        seen_done = 1'b0;
        outer_n = on;
        inner_n = in;
        start = 1'b1;
        ev.evt_ready = 1'b1;
        while (!seen_done && cyc < n * 4 + 20) begin
            @(negedge clk);
            cyc++;
            if (poke && !done) begin
                start   = 1'b1;
                outer_n = 8'($urandom);
                inner_n = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL %s busy cyc=%0d got=%b want=1", name, cyc, busy);
            end
            if (done === 1'b1) begin
                seen_done = 1'b1;
                checks++;
                if (idx != n || ev.evt_valid !== 1'b0) begin
                    errors++; $display("FAIL %s done_events got=%0d valid=%b want=%0d valid=0", name, idx, ev.evt_valid, n);
                end
                if (mode == 0) begin
                    checks++;
                    if (cyc != n + 1) begin
                        errors++; $display("FAIL %s done_cycle got=%0d want=%0d", name, cyc, n + 1);
                    end
                end
            end else if (ev.evt_valid === 1'b1) begin
                checks++;
                if (idx >= n) begin
                    errors++; $display("FAIL %s extra_event got=%0d want<%0d", name, idx, n);
                end else if (ev.evt_type !== e_t[idx] || ev.x_idx !== e_x[idx]
                             || (e_t[idx] && ev.y_idx !== e_y[idx])
                             || ev.act1 !== e_a1[idx] || ev.act2 !== e_a2[idx]) begin
                    errors++;
                    $display("FAIL %s event%0d got t=%b x=%0d y=%0d a1=%0d a2=%0d want t=%b x=%0d y=%0d a1=%0d a2=%0d",
                             name, idx, ev.evt_type, ev.x_idx, ev.y_idx, ev.act1, ev.act2,
                             e_t[idx], e_x[idx], e_y[idx], e_a1[idx], e_a2[idx]);
                end
                if (mode == 0 && cyc != idx + 1) begin
                    errors++; $display("FAIL %s event_cycle got=%0d want=%0d", name, cyc, idx + 1);
                end
            end else begin
                checks++; errors++;
                $display("FAIL %s valid_gap cyc=%0d got valid=0 want valid=1 or done=1", name, cyc);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc - 1) % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            ev.evt_ready = rdy;
            if (ev.evt_valid === 1'b1 && rdy && done !== 1'b1) idx++;
        end
        if (!seen_done) begin
            checks++; errors++;
            $display("FAIL %s timeout got events=%0d want done after %0d", name, idx, n);
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || ev.evt_valid !== 1'b0 || ev.x_idx !== fx
                || ev.y_idx !== fy || ev.act1 !== a1 || ev.act2 !== a2) begin
                errors++;
                $display("FAIL %s final%0d got d=%b b=%b v=%b x=%0d y=%0d a1=%0d a2=%0d want 0 0 0 x=%0d y=%0d a1=%0d a2=%0d",
                         name, k, done, busy, ev.evt_valid, ev.x_idx, ev.y_idx, ev.act1, ev.act2,
                         fx, fy, a1, a2);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (ev.evt_valid !== 1'b0 || ev.evt_type !== 1'b0 || busy !== 1'b0 || done !== 1'b0
            || ev.x_idx !== 8'd0 || ev.y_idx !== 8'd0 || ev.act1 !== 8'd0 || ev.act2 !== 8'd0) begin
            errors++;
            $display("FAIL %s got v=%b t=%b b=%b d=%b x=%0d y=%0d a1=%0d a2=%0d want all zero",
                     name, ev.evt_valid, ev.evt_type, busy, done, ev.x_idx, ev.y_idx, ev.act1, ev.act2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ev.evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
    endtask

    task automatic test_abort_reset();
        start = 1'b1; outer_n = 8'd5; inner_n = 8'd5; ev.evt_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort_reset");
        repeat (3) @(negedge clk);
        check_reset_outputs("abort_hold");
        rst_n = 1'b1;
        run_seq(8'd3, 8'd2, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 8; r++) begin
            run_seq(8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)),
                    2, 1'($urandom_range(0, 1)), $sformatf("random%0d", r));
        end
    endtask

    initial begin
        ev.evt_ready = 1'b0;
        @(negedge clk);
        test_reset();
        run_seq(8'd10, 8'd10, 0, 1'b0, "full_10x10");
        run_seq(8'd0, 8'd5, 0, 1'b0, "zero_outer");
        run_seq(8'd3, 8'd0, 0, 1'b0, "zero_inner");
        run_seq(8'd2, 8'd2, 1, 1'b0, "toggle_2x2");
        run_seq(8'd4, 8'd3, 0, 1'b1, "restart_ignored");
        run_seq(8'd255, 8'd1, 0, 1'b0, "max_outer");
        run_seq(8'd1, 8'd255, 2, 1'b0, "max_inner");
        test_abort_reset();
        test_random_runs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nested_loop_sched.md
NESTED_LOOP_SCHED -- requirements
Module: nested_loop_sched

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 The block SHALL expose these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  run request, sampled only in IDLE
- outer_n  in  8  outer loop count, latched on accepted start
- inner_n  in  8  inner loop count, latched on accepted start
- evt_ready  in  1  datapath accepts the current event
- evt_valid  out  1  event offered to the datapath
- evt_type  out  1  event kind: 0 = outer event, 1 = inner event
- x_idx  out  8  current outer index
- y_idx  out  8  current inner index
- act1  out  8  inner-event result register
- act2  out  8  outer-event counter
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse

Function
REQ-003 The state machine SHALL have four states:
- IDLE: evt_valid=0.
- OUTER: evt_valid=1, evt_type=0.
- INNER: evt_valid=1, evt_type=1.
- DONE: done=1 for exactly one cycle, then IDLE.
REQ-004 In IDLE with start=1, the block SHALL, at the next clock edge:
- latch outer_n and inner_n;
- clear x_idx, y_idx, act1 and act2;
- go to DONE if outer_n==0, else to OUTER.
REQ-005 The block SHALL ignore start in every state other than IDLE; the latched counts SHALL NOT change mid-run.
REQ-006 A handshake SHALL complete on any cycle where evt_valid and evt_ready are both 1.
REQ-007 While evt_valid=1 and evt_ready=0, evt_type, x_idx, y_idx, act1 and act2 SHALL hold stable.
REQ-008 On an OUTER handshake, act2 SHALL increment by 1 and y_idx SHALL clear to 0. The next state SHALL be:
- INNER if inner_n!=0;
- otherwise OUTER with x_idx+1 if x_idx<outer_n-1;
- otherwise DONE.
REQ-009 On an INNER handshake, act1 SHALL load act2. The next step SHALL be:
- if y_idx<inner_n-1: y_idx increments and the state stays INNER;
- else if x_idx<outer_n-1: x_idx increments and the state goes to OUTER;
- else: the state goes to DONE.
REQ-010 A full run SHALL issue exactly outer_n*(1+inner_n) events, in nested order: each outer event is followed by inner_n inner events.
REQ-011 With evt_ready held at 1, the block SHALL issue one event per cycle.
- The first evt_valid SHALL appear in the cycle after start is accepted.
- done SHALL assert in the cycle after the last handshake.
REQ-012 act1, act2, x_idx and y_idx SHALL retain their final values in DONE and IDLE until the next accepted start.
REQ-013 All counters SHALL be 8-bit unsigned; index compares SHALL use the latched counts, so x_idx and y_idx never wrap.
REQ-014 A count of 255 SHALL be legal: the indices reach 254 and do not overflow.
REQ-015 evt_valid SHALL be a registered state decode and SHALL NOT depend combinationally on evt_ready.

Reset
REQ-016 On a clock edge with rst_n=0, the block SHALL set:
- state = IDLE;
- evt_valid=0, evt_type=0, busy=0, done=0;
- x_idx=0, y_idx=0, act1=0, act2=0;
- latched outer_n and inner_n = 0.
REQ-017 Reset asserted mid-run SHALL abort the run: no done pulse and no further events.
REQ-018 After reset, the block SHALL be ready for start on the first cycle rst_n=1.

Verification
REQ-019 outer_n=10, inner_n=10, evt_ready=1, start pulsed at cycle 0:
- 110 events on cycles 1..110;
- done=1 on cycle 111, busy on cycles 1..111;
- final act2=10, act1=10, x_idx=9, y_idx=9.
REQ-020 outer_n=0, inner_n=5, start pulsed:
- no evt_valid;
- done pulses on the next cycle;
- act1=0, act2=0.
REQ-021 outer_n=3, inner_n=0:
- exactly 3 events, all evt_type=0, with x_idx 0, 1, 2;
- final act2=3, act1=0.
REQ-022 outer_n=2, inner_n=2, evt_ready toggling 1,0,0,1,...:
- outputs stay stable while ready=0;
- event sequence: O(x0), I(y0), I(y1), O(x1), I(y0), I(y1);
- act1 after each inner event = 1,1,2,2.
REQ-023 start re-pulsed while busy SHALL have no effect, and rst_n=0 mid-run SHALL set all outputs to their reset values on the next edge with no done pulse.
